// File: rtl/tick_time_counter.sv
// tick_time_counter: turns the periodic single-cycle tick from the tick
// generator into registered time-of-day fields (sub-second, second, minute,
// hour) with run/stop/set control, a synchronous clear and carry pulses.
// Optional build macro TICK_TIME_COUNTER_HOUR12_EN selects a 12-hour display
// (hours 1..12 plus an o_pm flag) instead of the default 24-hour count.
module tick_time_counter #(
    parameter int TICK_PER_SEC = 100,
    parameter int INIT_HOUR    = 12
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_tick,
    input  logic                            i_run,
    input  logic                            i_clear,
    input  logic                            i_set_mode,
    input  logic                            i_inc_sec,
    input  logic                            i_inc_min,
    input  logic                            i_inc_hour,
    output logic [$clog2(TICK_PER_SEC)-1:0] o_msec,
    output logic [5:0]                      o_sec,
    output logic [5:0]                      o_min,
    output logic [4:0]                      o_hour,
    output logic                            o_sec_pulse,
    output logic                            o_day_pulse,
    output logic [1:0]                      o_state
`ifdef TICK_TIME_COUNTER_HOUR12_EN
    ,
    output logic                            o_pm
`endif
);

    localparam int            MW       = $clog2(TICK_PER_SEC);
    localparam logic [MW-1:0] MSEC_MAX = MW'(TICK_PER_SEC - 1);

`ifdef TICK_TIME_COUNTER_HOUR12_EN
    // 12-hour mode always starts and clears at 12 AM
    localparam logic [4:0] HOUR_RST = 5'd12;
    localparam logic [4:0] HOUR_CLR = 5'd12;
`else
    localparam logic [4:0] HOUR_RST = 5'(INIT_HOUR);
    localparam logic [4:0] HOUR_CLR = 5'd0;
`endif

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_SET  = 2'b10
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [MW-1:0] msec_nx;
    logic [5:0]    sec_nx;
    logic [5:0]    min_nx;
    logic [4:0]    hour_nx;
    logic          sec_pulse_nx;
    logic          day_pulse_nx;
`ifdef TICK_TIME_COUNTER_HOUR12_EN
    logic          pm_nx;
`endif

    // Next hour value for both carry and manual increment
    function automatic logic [4:0] hour_step(input logic [4:0] h);
`ifdef TICK_TIME_COUNTER_HOUR12_EN
        return (h == 5'd12) ? 5'd1 : h + 5'd1;
`else
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
`endif
    endfunction

    assign o_state = state;

    // State register: follows the mode inputs one clock later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_STOP;
        end else begin
            state <= state_nx;
        end
    end

    // Mode selection: set mode outranks run, otherwise stopped
    always_comb begin
        state_nx = ST_STOP;
        if (i_set_mode) begin
            state_nx = ST_SET;
        end else if (i_run) begin
            state_nx = ST_RUN;
        end
    end

    // Field update: clear first, then ticking carry chain in RUN, then manual edits in SET
    always_comb begin
        msec_nx      = o_msec;
        sec_nx       = o_sec;
        min_nx       = o_min;
        hour_nx      = o_hour;
        sec_pulse_nx = 1'b0;
        day_pulse_nx = 1'b0;
`ifdef TICK_TIME_COUNTER_HOUR12_EN
        pm_nx        = o_pm;
`endif
        if (i_clear) begin
            msec_nx = '0;
            sec_nx  = 6'd0;
            min_nx  = 6'd0;
            hour_nx = HOUR_CLR;
`ifdef TICK_TIME_COUNTER_HOUR12_EN
            pm_nx   = 1'b0;
`endif
        end else if (state == ST_RUN && i_tick) begin
            if (o_msec == MSEC_MAX) begin
                msec_nx      = '0;
                sec_pulse_nx = 1'b1;
                if (o_sec == 6'd59) begin
                    sec_nx = 6'd0;
                    if (o_min == 6'd59) begin
                        min_nx  = 6'd0;
                        hour_nx = hour_step(o_hour);
`ifdef TICK_TIME_COUNTER_HOUR12_EN
                        if (o_hour == 5'd11) begin
                            pm_nx        = ~o_pm;
                            day_pulse_nx = o_pm;
                        end
`else
                        day_pulse_nx = (o_hour == 5'd23);
`endif
                    end else begin
                        min_nx = o_min + 6'd1;
                    end
                end else begin
                    sec_nx = o_sec + 6'd1;
                end
            end else begin
                msec_nx = o_msec + MW'(1);
            end
        end else if (state == ST_SET) begin
            msec_nx = '0;
            if (i_inc_sec) begin
                sec_nx = (o_sec == 6'd59) ? 6'd0 : o_sec + 6'd1;
            end
            if (i_inc_min) begin
                min_nx = (o_min == 6'd59) ? 6'd0 : o_min + 6'd1;
            end
            if (i_inc_hour) begin
                hour_nx = hour_step(o_hour);
`ifdef TICK_TIME_COUNTER_HOUR12_EN
                if (o_hour == 5'd11) begin
                    pm_nx = ~o_pm;
                end
`endif
            end
        end
    end

    // Time field and pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_msec      <= '0;
            o_sec       <= 6'd0;
            o_min       <= 6'd0;
            o_hour      <= HOUR_RST;
            o_sec_pulse <= 1'b0;
            o_day_pulse <= 1'b0;
`ifdef TICK_TIME_COUNTER_HOUR12_EN
            o_pm        <= 1'b0;
`endif
        end else begin
            o_msec      <= msec_nx;
            o_sec       <= sec_nx;
            o_min       <= min_nx;
            o_hour      <= hour_nx;
            o_sec_pulse <= sec_pulse_nx;
            o_day_pulse <= day_pulse_nx;
`ifdef TICK_TIME_COUNTER_HOUR12_EN
            o_pm        <= pm_nx;
`endif
        end
    end

endmodule

// File: doc/tick_time_counter.md
Name: tick_time_counter

Overview:
- Consumer end of the tick generator. Turns a single-cycle periodic tick into registered time-of-day fields: sub-second, second, minute and hour.
- Sits between the tick generator and the FND/display mux of the digital clock.
- Provides run/stop, clear and a set mode for manually incrementing fields, plus carry pulses for downstream blocks.

Parameters:
- TICK_PER_SEC, 100, number of i_tick pulses per second; o_msec counts 0..TICK_PER_SEC-1
- INIT_HOUR, 12, hour value loaded at reset (0..23)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- i_tick  input  1  single-cycle pulse from the tick generator
- i_run  input  1  level; 1 = counting enabled, 0 = stopped
- i_clear  input  1  single-cycle pulse; zero all fields
- i_set_mode  input  1  level; 1 = manual set mode
- i_inc_sec  input  1  single-cycle pulse; increment second (set mode only)
- i_inc_min  input  1  single-cycle pulse; increment minute (set mode only)
- i_inc_hour  input  1  single-cycle pulse; increment hour (set mode only)
- o_msec  output  $clog2(TICK_PER_SEC)  sub-second count
- o_sec  output  6  seconds 0..59
- o_min  output  6  minutes 0..59
- o_hour  output  5  hours 0..23
- o_sec_pulse  output  1  one-cycle pulse when o_sec advances by carry
- o_day_pulse  output  1  one-cycle pulse when o_hour wraps 23->0 by carry
- o_state  output  2  current FSM state (00 STOP, 01 RUN, 10 SET)

Behaviour:
- Reset (rst=0, asynchronous): o_msec=0, o_sec=0, o_min=0, o_hour=INIT_HOUR, both pulses=0, state=STOP. Assertion mid-count takes effect immediately, without waiting for clk.
- FSM, evaluated each clk in priority order:
  - i_set_mode=1 -> SET
  - else i_run=1 -> RUN
  - else -> STOP
  - The state register updates one clk after the input changes.
- RUN: each i_tick increments o_msec.
  - o_msec wraps TICK_PER_SEC-1 -> 0 and carries to o_sec.
  - o_sec wraps 59 -> 0 and carries to o_min.
  - o_min wraps 59 -> 0 and carries to o_hour.
  - o_hour wraps 23 -> 0.
  - All carries resolve in the same clk. Fields are registered, so they update on the clk edge after the clk where i_tick=1 (latency 1).
- o_sec_pulse is high for exactly the one clk in which the carry-updated o_sec value first appears. o_day_pulse is timed the same way for the hour 23->0 carry.
- STOP: i_tick ignored; fields hold.
- SET:
  - i_tick ignored; o_msec held at 0.
  - i_inc_sec/min/hour increment only their own field modulo 60/60/24, with no carry and no pulse outputs.
  - Simultaneous inc pulses are all applied in the same clk.
  - Leaving SET resumes from the edited values with o_msec=0.
- i_inc_* outside SET are ignored.
- i_clear has highest priority in any state:
  - o_msec, o_sec, o_min and o_hour go to 0 (not INIT_HOUR) on the next edge.
  - A tick or inc in the same clk is discarded.
  - State is unaffected.
- i_tick held high for multiple clks counts once per clk.

Optional Feature:
- Macro: TICK_TIME_COUNTER_HOUR12_EN.
- Defined:
  - o_hour runs 1..12.
  - Extra output o_pm (1 bit) is added.
  - Carry sequence is 11 AM -> 12 PM -> 1 PM ... 11 PM -> 12 AM; o_pm toggles on the 11->12 transition.
  - o_day_pulse fires on 11 PM -> 12 AM.
  - Reset hour is 12 with o_pm=0. i_clear sets hour=12, o_pm=0.
  - Set-mode hour increment wraps 12 -> 1, toggling o_pm on 11->12.
- Not defined: 24-hour behaviour as above; no o_pm port.

Test Plan:
- Reset with INIT_HOUR=12, then release rst -> o_msec=0, o_sec=0, o_min=0, o_hour=12, state STOP; 5 ticks while i_run=0 -> fields unchanged.
- TICK_PER_SEC=4, i_run=1, apply 4 ticks -> o_msec 1,2,3,0 and o_sec=1 one clk after the 4th tick; o_sec_pulse high exactly one clk.
- Preload via set mode to 23:59:59, o_msec=3, then RUN and 1 tick -> 00:00:00, o_day_pulse one clk, o_sec_pulse one clk.
- SET with fields at 00:59:59, i_inc_sec + i_inc_min in the same clk -> 00:00:00, hour unchanged, no pulses; ticks during SET ignored.
- RUN at 10:20:30, i_clear coincident with i_tick -> all fields 0 next clk, state remains RUN; next tick -> o_msec=1.
- Assert rst asynchronously between clk edges mid-run -> outputs reset immediately; HOUR12_EN build: 11:59:59 AM + carry -> 12:00:00, o_pm=1.
